// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, requester IDs
// and the legal read-latency range.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 7;
  localparam int CNT_W       = 3;

  function automatic logic lat_legal(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on conflicts; default is data-over-fetch.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_winner_i,
`endif
  output logic any_req_o,
  output logic winner_o
);

  assign any_req_o = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner_o = FETCH;
    if (if_req_i && d_req_i) begin
      winner_o = ~last_winner_i;
    end else if (d_req_i) begin
      winner_o = DATA;
    end
  end
`else
  // Data wins ties so the M phase is never stalled behind a fetch.
  always_comb begin
    winner_o = FETCH;
    if (d_req_i) begin
      winner_o = DATA;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-master front end for the unified I/D memory: accepts one fetch or data
// transaction at a time. Optional round-robin arbitration via MEM_ARB_RR_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no transaction; requests sampled every edge
// ST_ISSUE | one cycle: winner's gnt, mem_en (and mem_we for stores)
// ST_WAIT  | LATENCY cycles counting down; read data captured at zero
// ST_DONE  | one cycle: winner's valid; requests sampled as in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (!lat_legal(LATENCY)) begin : g_bad_latency
    $error("mem_arbiter: LATENCY out of range 1..7");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             winner_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    if_rdata_q;
  logic [DW-1:0]    d_rdata_q;

  logic any_req;
  logic winner;
  logic accept;
  logic cnt_last;

`ifdef MEM_ARB_RR_EN
  logic last_winner_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner_q <= FETCH;
    end else if (accept) begin
      last_winner_q <= winner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
`ifdef MEM_ARB_RR_EN
    .last_winner_i (last_winner_q),
`endif
    .any_req_o     (any_req),
    .winner_o      (winner)
  );

  assign accept   = any_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_last) state_d = ST_DONE;
      ST_DONE:  state_d = any_req ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    if_valid = 1'b0;
    d_valid  = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_q;
        if_gnt = (winner_q == FETCH);
        d_gnt  = (winner_q == DATA);
      end
      ST_DONE: begin
        if_valid = (winner_q == FETCH);
        d_valid  = (winner_q == DATA);
      end
      default: ;
    endcase
  end

  // Inputs are latched only at acceptance; later changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q <= FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      winner_q <= winner;
      we_q     <= (winner == DATA) && d_we;
      addr_q   <= (winner == DATA) ? d_addr : if_addr;
      wdata_q  <= (winner == DATA) ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_ISSUE: cnt_q <= LAT_LOAD;
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_last && !we_q) begin
            if (winner_q == DATA) begin
              d_rdata_q <= mem_rdata;
            end else begin
              if_rdata_q <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: instruction fetch (F phase) and data load/store (M phase).
- Accepts level requests and picks one winner per transaction.
- Sequences the memory enable/write strobes and waits a fixed read latency.
- Returns captured read data with a one-cycle completion pulse.
- Sits between the control unit and the memory array; the memory sees one master only.

Parameters:
- AW, 32, address width of requesters and memory.
- DW, 32, data width.
- LATENCY, 1, cycles from the memory enable edge to read data valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request, level.
- if_addr  in  AW  fetch address (pc).
- if_gnt  out  1  fetch accepted, 1-cycle pulse.
- if_valid  out  1  fetch complete, 1-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  DW  fetched word.
- d_req  in  1  data request, level.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address (ma).
- d_wdata  in  DW  store data.
- d_gnt  out  1  data accepted, 1-cycle pulse.
- d_valid  out  1  data complete, 1-cycle pulse (load data or store ack).
- d_rdata  out  DW  loaded word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe, only with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; wait counter 0; last_winner = fetch.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample requests at each rising edge.
  - If any request is high: latch winner, addr, we, wdata; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Winner's gnt = 1, mem_en = 1.
  - mem_we = latched we; mem_addr/mem_wdata = latched values.
  - Counter loads LATENCY; go to WAIT.
- WAIT (LATENCY cycles):
  - mem_en = 0; counter decrements.
  - On the edge where the counter reaches 0, capture mem_rdata into the winner's rdata register (loads only); go to DONE.
- DONE (1 cycle):
  - Winner's valid = 1.
  - Stores leave d_rdata unchanged.
  - Requests are sampled at the end of DONE exactly as in IDLE. New winner -> ISSUE; otherwise -> IDLE.
- Latency: accept edge E -> gnt in cycle E+1 -> valid in cycle E+2+LATENCY. Back-to-back period is LATENCY+2 cycles.
- rdata registers hold their last captured value until the next load for the same requester.
- Arbitration: both requests high at a sampling edge -> data wins (fixed priority; prevents M-phase stall).
- Requester rules:
  - Keep req high until gnt is seen.
  - Deassert req no later than its DONE cycle, or a new transaction starts.
  - Dropping req after acceptance does not cancel the transaction.
- Inputs are sampled only at acceptance; addr/wdata changes after that are ignored.
- Only one transaction is in flight; no requests are sampled in ISSUE or WAIT.
- Reset mid-operation: immediate return to IDLE, pulses cleared.
  - A store whose ISSUE edge already occurred is committed in memory.
  - Otherwise no write occurs.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - On simultaneous requests, the winner is the requester not equal to last_winner (round-robin).
  - last_winner is updated at every acceptance.
  - Reset value is fetch, so data wins the first conflict.
  - A lone request always wins.
- Undefined: fixed data-over-fetch priority; last_winner logic is absent.

Decomposition:
- Shared package/defines:
  - State encoding constants: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - Requester IDs: FETCH = 1'b0, DATA = 1'b1.
  - LATENCY range limit.
- Sub-module mem_arb_pick: combinational winner selection from if_req, d_req, last_winner. Contains the MEM_ARB_RR_EN variant.
- Sequential logic (FSM, counter, capture) stays in mem_arbiter.

Test Plan:
- Reset then fetch only, LATENCY=1, if_addr=0x10, memory holds 0xDEADBEEF:
  - if_gnt high in cycle 1 after the accept edge; mem_en=1, mem_we=0, mem_addr=0x10.
  - if_valid high in cycle 3 with if_rdata=0xDEADBEEF.
  - busy high for 3 cycles.
- Store then load, LATENCY=1: d_we=1, d_addr=0x20, d_wdata=0x12345678, then load 0x20.
  - Store: d_valid pulse, d_rdata unchanged, mem_we=1 only in ISSUE.
  - Load: returns 0x12345678.
- Both requests at the same edge, fixed priority: data served first. Fetch is then served by acceptance at the end of the data DONE cycle; if_gnt comes LATENCY+2 cycles after d_gnt.
- MEM_ARB_RR_EN, both requests held continuously for 4 transactions: grants alternate data, fetch, data, fetch.
- LATENCY=3, reset asserted during WAIT:
  - All outputs 0 asynchronously; no valid pulse.
  - After release, a new fetch completes normally in 5 cycles.
- Request held through DONE: a second transaction starts, ISSUE immediately follows DONE. A request dropped before acceptance produces no gnt and no mem_en.
